// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// Outputs are registered from the FSM state, so tx/busy/done share one cycle of lag.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 326,
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_W       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done_tick,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic              push, pop;

    state_t            state, state_n;
    logic [BAUD_W-1:0] baud, baud_n;
    logic [2:0]        bit_idx, bit_n;
    logic [7:0]        shift, shift_n;
    logic              baud_last;

    // Full is the registered flag, so a same-cycle pop never rescues a write.
    assign push = wr_en && !fifo_full;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_comb begin
        count_nxt = fifo_count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && fifo_full) overflow <= 1'b1;
            fifo_count <= count_nxt;
            fifo_full  <= (count_nxt == DEPTH_C);
            fifo_empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            baud         <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_n;
            baud         <= baud_n;
            bit_idx      <= bit_n;
            shift        <= shift_n;
            tx           <= (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
            tx_busy      <= (state != IDLE);
            tx_done_tick <= (state == STOP) && baud_last;
        end
    end

    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_n     = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        baud_last = (baud == BAUD_LAST);
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    baud_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 1'b1;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_n = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: an independent serial decoder recovers frames
// from tx and they are checked against hand-computed bit patterns and byte orders.
module tb_uart_tx_buffered;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx, tx_busy, tx_done_tick, fifo_full, fifo_empty, overflow;
    logic [2:0] fifo_count;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit i = i-th bit on the line (start .. stop)
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    logic [9:0] frame_q[$];
    int         start_q[$];
    vec_t       vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (tx_done_tick === 1'b1) done_cnt = done_cnt + 1;
    end

    // Serial decoder: samples each bit near its centre; frames hit by reset are dropped.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                logic [9:0] f;
                bit ab;
                int st;
                st = cyc;
                ab = 1'b0;
                f  = '0;
                for (int i = 0; i < 10; i++) begin
                    for (int k = 0; k < ((i == 0) ? CPB / 2 : CPB); k++) begin
                        @(negedge clk);
                        if (reset !== 1'b1) ab = 1'b1;
                    end
                    f[i] = tx;
                end
                if (!ab) begin
                    frame_q.push_back(f);
                    start_q.push_back(st);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
    endtask

    task automatic wr_end();
        @(negedge clk);
        wr_en   = 1'b0;
        wr_data = 8'hxx;
    endtask

    task automatic wait_frames(input string name, input int n, input int limit);
        for (int k = 0; k < limit && frame_q.size() < n; k++) @(negedge clk);
        chk(name, frame_q.size(), n);
    endtask

    task automatic wait_idle(input string name, input int limit);
        for (int k = 0; k < limit && (tx_busy !== 1'b0 || fifo_empty !== 1'b1); k++) @(negedge clk);
        chk(name, {tx_busy, fifo_empty}, 2'b01);
    endtask

    initial begin
        logic [7:0] exp_b[$];
        int base, gaps, n0;
        bit seen;

        vecs[0] = '{8'h55, 10'h2AA};
        vecs[1] = '{8'hAA, 10'h354};
        vecs[2] = '{8'h00, 10'h200};
        vecs[3] = '{8'hFF, 10'h3FE};
        vecs[4] = '{8'h01, 10'h202};
        vecs[5] = '{8'h80, 10'h300};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_flags", {tx_busy, tx_done_tick, fifo_full, fifo_empty, overflow}, 5'b00010);
        chk("rst_count", fifo_count, 3'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte with exact latency and done-tick placement
        frame_q.delete();
        base = done_cnt;
        wr(8'h55);
        @(posedge clk); #1;                       // edge N
        chk("lat_cnt_N", fifo_count, 3'd1);
        chk("lat_tx_N", tx, 1'b1);
        wr_end();
        @(posedge clk); #1;                       // edge N+1: popped
        chk("lat_tx_N1", tx, 1'b1);
        chk("lat_empty_N1", {fifo_empty, fifo_count}, {1'b1, 3'd0});
        @(posedge clk); #1;                       // edge N+2: start bit
        chk("lat_tx_N2", {tx, tx_busy}, 2'b01);
        repeat (10 * CPB - 2) @(posedge clk);
        #1;
        chk("done_early", {tx_done_tick, tx}, 2'b01);
        @(posedge clk); #1;
        chk("done_last", {tx_done_tick, tx, tx_busy}, 3'b111);
        @(posedge clk); #1;
        chk("done_after", {tx_done_tick, tx_busy, tx}, 3'b001);
        chk("done_once", done_cnt - base, 1);
        wait_frames("single_frames", 1, 4 * CPB);
        if (frame_q.size() > 0) chk("single_bits", frame_q[0], 10'h2AA);

        // Table of single frames
        for (int i = 0; i < 6; i++) begin
            frame_q.delete();
            base = done_cnt;
            wr(vecs[i].data);
            wr_end();
            wait_frames($sformatf("vec%0d_arrive", i), 1, 14 * CPB);
            if (frame_q.size() > 0) chk($sformatf("vec%0d_bits", i), frame_q[0], vecs[i].frame);
            wait_idle($sformatf("vec%0d_idle", i), 4 * CPB);
            chk($sformatf("vec%0d_done", i), done_cnt - base, 1);
        end

        // Back-to-back: no idle gap, busy held high, four done ticks
        frame_q.delete();
        start_q.delete();
        base = done_cnt;
        gaps = 0;
        seen = 1'b0;
        wr(8'h55); wr(8'hAA); wr(8'h0F); wr(8'hF0);
        wr_end();
        for (int k = 0; k < 50 * CPB && done_cnt - base < 4; k++) begin
            @(negedge clk);
            if (tx_busy === 1'b1) seen = 1'b1;
            else if (seen) gaps++;
        end
        chk("b2b_done", done_cnt - base, 4);
        chk("b2b_busy_gaps", gaps, 0);
        chk("b2b_empty", fifo_empty, 1'b1);
        wait_frames("b2b_frames", 4, 4 * CPB);
        exp_b = '{8'h55, 8'hAA, 8'h0F, 8'hF0};
        for (int i = 0; i < 4 && i < frame_q.size(); i++)
            chk($sformatf("b2b_byte%0d", i), frame_q[i][8:1], exp_b[i]);
        for (int i = 1; i < 4 && i < start_q.size(); i++)
            chk($sformatf("b2b_spacing%0d", i), start_q[i] - start_q[i-1], 10 * CPB);
        wait_idle("b2b_idle", 4 * CPB);

        // Overflow: six writes while idle, sixth dropped
        frame_q.delete();
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44); wr(8'h55); wr(8'h66);
        @(posedge clk); #1;
        chk("ovf_full", {fifo_full, fifo_count}, {1'b1, 3'd4});
        chk("ovf_flag", overflow, 1'b1);
        wr_end();
        wait_frames("ovf_frames", 5, 60 * CPB);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5 && i < frame_q.size(); i++)
            chk($sformatf("ovf_byte%0d", i), frame_q[i][8:1], exp_b[i]);
        repeat (20 * CPB) @(negedge clk);
        chk("ovf_no_sixth", frame_q.size(), 5);
        chk("ovf_sticky", overflow, 1'b1);

        // Wrap: 12 bytes in bursts of 3, each burst pushed while a frame is on the line
        frame_q.delete();
        exp_b.delete();
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 3; j++) begin
                wr(8'hA0 + 8'(b * 3 + j));
                exp_b.push_back(8'hA0 + 8'(b * 3 + j));
            end
            wr_end();
            for (int k = 0; k < 40 * CPB && fifo_count != 0; k++) @(negedge clk);
        end
        wait_frames("wrap_frames", 12, 60 * CPB);
        for (int i = 0; i < 12 && i < frame_q.size(); i++)
            chk($sformatf("wrap_byte%0d", i), frame_q[i][8:1], exp_b[i]);
        wait_idle("wrap_idle", 14 * CPB);

        // Reset in DATA bit 3 of 0xAA with two bytes queued
        frame_q.delete();
        wr(8'hAA);
        @(posedge clk); #1;
        n0 = cyc;
        wr(8'h01); wr(8'h02);
        wr_end();
        for (int k = 0; k < 20 * CPB && cyc < n0 + 2 + 4 * CPB + CPB / 2; k++) @(negedge clk);
        chk("mid_pre_state", {tx_busy, fifo_count}, {1'b1, 3'd2});
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_fifo", {fifo_empty, fifo_full, fifo_count}, {1'b1, 1'b0, 3'd0});
        chk("mid_rst_busy", tx_busy, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30 * CPB) @(negedge clk);
        chk("mid_no_frames", frame_q.size(), 0);
        chk("mid_ovf_clear", overflow, 1'b0);
        wr(8'h3C);
        wr_end();
        wait_frames("mid_new_frame", 1, 14 * CPB);
        if (frame_q.size() > 0) chk("mid_new_bits", frame_q[0], 10'h278);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
8N1 UART transmitter with a small byte FIFO at its input. It is the transmit-side counterpart of the receive path in top_uart. Host logic pushes bytes with a single-cycle write strobe. The block frames each byte as start + 8 data bits (LSB first) + stop and serialises it on tx at a fixed clocks-per-bit rate. It also serves as the bench/loopback source driving top_uart's rx.

Parameters:
CLKS_PER_BIT, 326, clock cycles per serial bit (50 MHz clk); legal range ≥ 2
FIFO_DEPTH, 4, input FIFO entries; power of two, ≥ 2
ADDR_W, 2, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
wr_en  in  1  push wr_data into FIFO this cycle
wr_data  in  8  byte to transmit
tx  out  1  serial line, idle high
tx_busy  out  1  high while a frame is on the line (START..STOP)
tx_done_tick  out  1  one-cycle pulse on the last cycle of each stop bit
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
fifo_empty  out  1  FIFO holds 0 entries
fifo_count  out  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH
overflow  out  1  sticky: a write was attempted while full

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, tx_busy=0, tx_done_tick=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0.
  - FSM=IDLE; bit counter, baud counter and pointers cleared.
  - Reset mid-frame aborts the frame immediately, with tx returning high. Queued bytes are discarded.
- FIFO:
  - Registered write when wr_en=1 and fifo_full=0.
  - wr_en=1 while fifo_full=1: the byte is dropped and overflow is set. This holds even if a pop happens the same cycle; full is evaluated on the registered flag.
  - Simultaneous push and pop with 0<count<DEPTH: count is unchanged and the data order is preserved.
  - Pointers wrap modulo FIFO_DEPTH. Flags and count are registered and consistent on every cycle.
- FSM states: IDLE, START, DATA, STOP. tx is a registered output driven from the state and shift register.
  - IDLE:
    - tx=1, tx_busy=0.
    - If fifo_empty=0: pop the head into an 8-bit shift register, clear the baud counter, and go to START.
  - START:
    - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - tx=shift[0] for CLKS_PER_BIT cycles each, shifting right after each bit.
    - After bit index 7, go to STOP.
  - STOP:
    - tx=1 for CLKS_PER_BIT cycles.
    - On the final cycle, assert tx_done_tick for exactly one cycle.
    - Next state: if FIFO non-empty, pop and go directly to START, giving back-to-back frames with no idle gap; else go to IDLE.
- Timing:
  - Write latency: wr_en sampled at edge N into an empty FIFO with FSM in IDLE → pop at edge N+1 → tx low from edge N+2.
  - Frame length is exactly 10×CLKS_PER_BIT cycles (3260 at default).
- tx_busy is high from START entry through the final STOP cycle. It stays high continuously across back-to-back frames.
- The baud counter is width ceil(log2(CLKS_PER_BIT)) and counts 0..CLKS_PER_BIT-1. It has no drift across frames.
- wr_data is not sampled when wr_en=0. X on wr_data while wr_en=0 must not propagate.

Test Plan:
- Single byte: reset released, write 0x55 → tx low 2 cycles after the write edge, then LSB-first bits 1,0,1,0,1,0,1,0, then stop high. Each bit lasts 326 cycles; tx_done_tick pulses once at cycle 3260 of the frame.
- Back-to-back: write 0x55,0xAA,0x0F,0xF0 on consecutive cycles → four frames with no idle gap between them (start bit immediately follows the stop bit), 4 tx_done_tick pulses, tx_busy high continuously, fifo_empty=1 after the 4th pop.
- Overflow: 6 writes on consecutive cycles while idle → byte 1 popped; bytes 2-5 fill the FIFO (fifo_full=1, count=4); byte 6 dropped; overflow=1 held until reset; only 5 frames transmitted.
- Reset mid-frame: assert reset during DATA bit 3 of 0xAA with 2 bytes queued → tx=1 and fifo_empty=1 asynchronously. After release, no further frames appear until a new write.
- Loopback: connect tx to top_uart rx and send 0x55,0xAA,0x0F,0xF0 → top_uart rx_done_tick fires 4 times with matching bytes.
- Wrap: 12 bytes pushed in bursts of 3 while transmitting → pointers wrap 3 times and output byte order equals input order.
